led_controller: RTL and testbench
=================================

LED_CONTROLLER -- requirements
Module: led_controller

Interface
REQ-001 The module SHALL have parameter N, default 6, meaning the number of switch/button/LED channels.
REQ-002 The module SHALL have parameter DEBOUNCE_CYCLES, default 4, range >= 1, meaning how many consecutive cycles a synchronized button level must hold before it is accepted.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port switches, input, N bits: asynchronous level inputs, one per LED.
REQ-006 The module SHALL have port buttons, input, N bits: asynchronous, bouncy push-buttons, one per LED, active-high.
REQ-007 The module SHALL have port leds, output, N bits: registered LED drive, active-high.

Function
REQ-008 The module SHALL pass each switches bit and each buttons bit through its own 2-flop synchronizer before any other use.
REQ-009 The module SHALL give each channel i an independent invert flag inv[i].
REQ-010 The module SHALL register the output, updating leds[i] every cycle to sw_sync[i] XOR inv[i].
REQ-011 Switch latency SHALL be exactly 3 rising edges from the first edge at which the new level is sampled to the edge at which leds shows it.
- Edges 1-2: synchronizer.
- Edge 3: output register.
REQ-012 The module SHALL hold a debounced level deb[i] and a counter cnt[i] for each button, wide enough for DEBOUNCE_CYCLES.
- If btn_sync[i] equals deb[i]: cnt[i] is cleared.
- Otherwise: cnt[i] increments.
- When cnt[i] = DEBOUNCE_CYCLES-1 and the level still differs: deb[i] takes btn_sync[i] and cnt[i] clears.
REQ-013 Any button pulse or bounce shorter than DEBOUNCE_CYCLES synchronized cycles SHALL NOT change deb[i].
REQ-014 The module SHALL hold deb_d[i], a one-cycle delayed copy of deb[i].
REQ-015 A press SHALL be detected when deb[i]=1 and deb_d[i]=0; on that edge inv[i] SHALL toggle.
REQ-016 Releases (falling edges of deb[i]) SHALL have no effect on inv[i].
REQ-017 Holding a button for any length of time SHALL produce exactly one toggle.
REQ-018 The module SHALL NOT auto-repeat while a button is held.
REQ-019 Button latency SHALL be DEBOUNCE_CYCLES+4 rising edges from the first edge sampling the pressed level to the edge at which leds shows the inversion.
- Edges 1-2: synchronizer.
- Edges 3 to DEBOUNCE_CYCLES+2: deb update.
- Edge DEBOUNCE_CYCLES+3: inv toggle.
- Edge DEBOUNCE_CYCLES+4: leds update.
REQ-020 Channels SHALL be fully independent; simultaneous presses on several buttons SHALL toggle each corresponding inv bit on the same edge.
REQ-021 A switch change and an inv toggle on the same channel in the same cycle SHALL both take effect.
- The output is the XOR of the new switch value and the new inv value.
REQ-022 A second toggle on a channel SHALL require deb[i] to return to 0 for at least one cycle and then rise again.

Reset
REQ-023 While rst=1 at a rising edge, the module SHALL clear to 0: all synchronizer flops, deb, deb_d, cnt, inv and leds.
REQ-024 The first cycle after reset release SHALL NOT produce a press event, even if a button is held through reset.
- deb and deb_d both start at 0.
- A button held through reset counts as a fresh press only after debouncing, per REQ-012.
REQ-025 Asserting rst mid-debounce or mid-toggle SHALL abort the operation.
- No toggle is retained.
- leds = 0 on the edge after rst is sampled high.

Verification (N=6, DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-026 Reset then idle:
- Stimulus: rst=1 for 2 cycles, then all inputs 0.
- Required response: leds = 000000 throughout.
REQ-027 Walking switch:
- Stimulus: set switches[k]=1 for 5 cycles, then 0, for k=0..5.
- Required response: leds = one-hot bit k, appearing 3 edges after the set and clearing 3 edges after the clear; no other bit changes.
REQ-028 Invert:
- Stimulus: switches=000001, then buttons[0] high for 10 cycles.
- Required response: leds[0] goes 1 then 0, 8 edges after the press is sampled, and stays 0 after release.
- A second press returns leds[0] to 1.
REQ-029 Bounce rejection:
- Stimulus: buttons[2] toggles every cycle for 12 cycles, then stays low.
- Required response: leds unchanged.
- A 3-cycle pulse is also rejected.
- A 4-cycle synchronized pulse toggles leds[2] exactly once.
REQ-030 Simultaneous events:
- Stimulus: switches=101010; buttons=111111 held 10 cycles.
- Required response: leds becomes 010101 on a single edge.
REQ-031 Reset mid-operation:
- Stimulus: press buttons[5]; assert rst 2 cycles after the press is sampled.
- Required response: leds = 000000 and no toggle after rst release while the button is still held, until DEBOUNCE_CYCLES+4 edges after release.
- Thereafter leds[5]=1 if the button remains held.

Source files
------------

// File: rtl/led_controller.sv
// led_controller: per-channel LED drive = synchronized switch XOR a
// press-toggled invert flag. Buttons are synchronized, debounced and
// edge-detected so that each accepted press toggles its channel exactly once.
module led_controller #(
  parameter int unsigned N               = 6,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] switches,
  input  logic [N-1:0] buttons,
  output logic [N-1:0] leds
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N-1:0]  sw_meta;
  logic [N-1:0]  sw_sync;
  logic [N-1:0]  btn_meta;
  logic [N-1:0]  btn_sync;
  logic [N-1:0]  deb;
  logic [N-1:0]  deb_d;
  logic [N-1:0]  inv;
  logic [CW-1:0] cnt [N];

  logic [N-1:0]  deb_nxt;
  logic [CW-1:0] cnt_nxt [N];
  logic [N-1:0]  press_c;

  // Two-flop synchronizers for both switch and button inputs
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta  <= '0;
      sw_sync  <= '0;
      btn_meta <= '0;
      btn_sync <= '0;
    end else begin
      sw_meta  <= switches;
      sw_sync  <= sw_meta;
      btn_meta <= buttons;
      btn_sync <= btn_meta;
    end
  end

  // Debounce next-state: a level must differ for DEBOUNCE_CYCLES straight cycles
  always_comb begin
    deb_nxt = deb;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = '0;
      if (btn_sync[i] != deb[i]) begin
        if (cnt[i] == CNT_LAST) begin
          deb_nxt[i] = btn_sync[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // Rising edge of the debounced level is a press; releases are ignored
  assign press_c = deb & ~deb_d;

  // Debounce state, edge-detect delay, invert flags and registered LED drive
  always_ff @(posedge clk) begin
    if (rst) begin
      deb   <= '0;
      deb_d <= '0;
      inv   <= '0;
      leds  <= '0;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      deb   <= deb_nxt;
      deb_d <= deb;
      inv   <= inv ^ press_c;
      leds  <= sw_sync ^ inv;
      for (int i = 0; i < N; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
    end
  end

endmodule

// File: tb/tb_led_controller.sv
// tb_led_controller: directed scenarios plus randomized traffic, every cycle
// checked against a window-based behavioural model of the LED controller.
module tb_led_controller;

  localparam int unsigned N = 6;
  localparam int unsigned D = 4;

  logic         clk;
  logic         rst;
  logic [N-1:0] switches;
  logic [N-1:0] buttons;
  logic [N-1:0] leds;

  int total = 0;
  int bad   = 0;

  led_controller #(.N(N), .DEBOUNCE_CYCLES(D)) dut (
    .clk      (clk),
    .rst      (rst),
    .switches (switches),
    .buttons  (buttons),
    .leds     (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state.
  // sw_p/bt_p: raw samples taken at the previous two edges ([1] is older).
  // bwin: the last D synchronized button levels seen by the debouncer.
  logic [N-1:0] sw_p [2];
  logic [N-1:0] bt_p [2];
  logic [N-1:0] bwin [D];
  logic [N-1:0] m_deb, m_debd, m_inv, m_leds;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  // Advance the model by one rising edge using the inputs sampled there.
  task automatic model_edge(input logic r, input logic [N-1:0] sw, input logic [N-1:0] bt);
    logic [N-1:0] newdeb;
    if (r) begin
      sw_p[0] = '0; sw_p[1] = '0;
      bt_p[0] = '0; bt_p[1] = '0;
      for (int k = 0; k < D; k++) bwin[k] = '0;
      m_deb = '0; m_debd = '0; m_inv = '0; m_leds = '0;
    end else begin
      for (int k = D - 1; k > 0; k--) bwin[k] = bwin[k-1];
      bwin[0] = bt_p[1];
      // A level is accepted once the last D synchronized samples all disagree with it.
      newdeb = m_deb;
      for (int i = 0; i < N; i++) begin
        logic all_diff;
        all_diff = 1'b1;
        for (int k = 0; k < D; k++) if (bwin[k][i] == m_deb[i]) all_diff = 1'b0;
        if (all_diff) newdeb[i] = ~m_deb[i];
      end
      m_leds = sw_p[1] ^ m_inv;
      m_inv  = m_inv ^ (m_deb & ~m_debd);
      m_debd = m_deb;
      m_deb  = newdeb;
      sw_p[1] = sw_p[0]; sw_p[0] = sw;
      bt_p[1] = bt_p[0]; bt_p[0] = bt;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge(rst, switches, buttons);
    #1;
    chk(tag, leds, m_leds);
  endtask

  task automatic steps(input int n, input string tag);
    for (int k = 0; k < n; k++) step(tag);
  endtask

  initial begin
    rst = 1'b1; switches = '0; buttons = '0;
    for (int k = 0; k < 2; k++) bwin[k] = '0;
    model_edge(1'b1, '0, '0);

    // Reset then idle
    steps(2, "reset");
    chk("reset_leds", leds, 6'b000000);
    rst = 1'b0;
    steps(10, "idle");
    chk("idle_leds", leds, 6'b000000);

    // Walking switch: one-hot appears 3 edges after set, clears 3 after clear
    for (int k = 0; k < N; k++) begin
      switches = N'(1 << k);
      steps(2, "walk_lat");
      chk("walk_pre", leds, 6'b000000);
      step("walk");
      chk("walk_on", leds, N'(1 << k));
      steps(2, "walk");
      switches = '0;
      steps(3, "walk_off");
      chk("walk_off", leds, 6'b000000);
    end

    // Invert via buttons[0]: inversion visible 8 edges after press sampled
    switches = 6'b000001;
    steps(5, "inv_setup");
    buttons = 6'b000001;
    steps(7, "inv_press");
    chk("inv_pre", leds, 6'b000001);
    step("inv_press");
    chk("inv_on", leds, 6'b000000);
    steps(2, "inv_hold");
    buttons = '0;
    steps(12, "inv_rel");
    chk("inv_rel", leds, 6'b000000);
    buttons = 6'b000001;
    steps(10, "inv_press2");
    buttons = '0;
    steps(12, "inv_rel2");
    chk("inv_second", leds, 6'b000001);

    // Bounce rejection on buttons[2]
    switches = '0;
    steps(5, "bnc_setup");
    for (int k = 0; k < 12; k++) begin
      buttons = (k % 2 == 0) ? 6'b000100 : 6'b000000;
      step("bounce");
    end
    buttons = '0;
    steps(12, "bounce");
    chk("bounce_rej", leds, 6'b000000);
    buttons = 6'b000100;
    steps(3, "pulse3");
    buttons = '0;
    steps(14, "pulse3");
    chk("pulse3_rej", leds, 6'b000000);
    buttons = 6'b000100;
    steps(4, "pulse4");
    buttons = '0;
    steps(14, "pulse4");
    chk("pulse4_tog", leds, 6'b000100);

    // Simultaneous presses on all channels
    rst = 1'b1;
    steps(2, "rst2");
    rst = 1'b0;
    switches = 6'b101010;
    steps(5, "sim_setup");
    chk("sim_pre", leds, 6'b101010);
    buttons = 6'b111111;
    steps(7, "sim");
    chk("sim_before", leds, 6'b101010);
    step("sim");
    chk("sim_flip", leds, 6'b010101);
    steps(2, "sim_hold");
    buttons = '0;
    steps(12, "sim_rel");
    chk("sim_after", leds, 6'b010101);

    // Reset mid-operation with buttons[5] held throughout
    rst = 1'b1;
    steps(2, "rst3");
    rst = 1'b0;
    switches = '0;
    steps(4, "mid_setup");
    buttons = 6'b100000;
    steps(2, "mid_press");
    rst = 1'b1;
    step("mid_rst");
    chk("mid_rst_leds", leds, 6'b000000);
    step("mid_rst");
    rst = 1'b0;
    steps(7, "mid_hold");
    chk("mid_no_tog", leds, 6'b000000);
    step("mid_hold");
    chk("mid_tog", leds, 6'b100000);
    steps(5, "mid_hold");
    buttons = '0;
    steps(12, "mid_rel");

    // Randomized traffic, including bounces and occasional reset
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 7) == 0) buttons ^= N'(1 << $urandom_range(0, N - 1));
      if ($urandom_range(0, 15) == 0) switches ^= N'(1 << $urandom_range(0, N - 1));
      rst = ($urandom_range(0, 399) == 0);
      step("random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
